cskip_pipe_adder: RTL
=====================

// Module: cskip_pipe_adder
// PURPOSE
// - Parametrised, pipelined carry-skip adder: WIDTH-bit add of x1+x2+cin, split into BLOCK-bit sub-adders.
// - One pipeline register per block. Each stage resolves its block's sum and skip/ripple carry-out.
// - valid/ready handshake on input and output, with full backpressure.
// - Successor to the fixed 32-bit combinational carry-skip adders. Sits in datapaths that need
//   throughput of 1 add/cycle at high fclk.
// PARAMETERS
// - WIDTH  32  operand/sum width; must be a multiple of BLOCK (elaboration $error otherwise)
// - BLOCK  8   bits per carry-skip block, >=1; NBLK = WIDTH/BLOCK = number of stages
// PORTS
// - clk        in   1      sole clock; all state updates on posedge
// - rst        in   1      synchronous, active-high reset
// - in_valid   in   1      x1/x2/cin valid this cycle
// - in_ready   out  1      stage 0 can accept; transfer when in_valid & in_ready
// - x1         in   WIDTH  operand A
// - x2         in   WIDTH  operand B
// - cin        in   1      carry in
// - out_valid  out  1      s/cout hold a completed result
// - out_ready  in   1      consumer accepts; transfer when out_valid & out_ready
// - s          out  WIDTH  sum
// - cout       out  1      carry out of bit WIDTH-1
// BEHAVIOUR
// - Reset: every stage valid=0 and every data register=0. Outputs: out_valid=0, s=0, cout=0, in_ready=1 in the first post-reset cycle.
// - Stage k (0..NBLK-1) registers:
//   - valid bit;
//   - s[BLOCK*(k+1)-1:0] computed so far;
//   - carry into block k+1;
//   - x1/x2 bits above block k.
// - Stage k input: block k bits plus the stage k-1 carry (cin for k=0).
// - Block k carry-out: gp_k = &(x1_k ^ x2_k); carry = gp_k ? carry_in_k : ripple/prefix carry of block k.
// - Register stage NBLK-1 drives s/cout/out_valid directly; no combinational path from x1/x2 to s.
// - Latency: with out_ready=1, a transfer in cycle t gives out_valid=1 with its result in cycle t+NBLK.
// - Throughput: 1 result/cycle sustained. Results leave in acceptance order.
// - Advance rule: stage k loads when (!valid_k) | load_{k+1}; load_NBLK = out_ready.
//   - in_ready = load_0, a combinational ready chain.
//   - No bubbles are inserted and none are required to be collapsed beyond this rule.
// - Hold: while out_valid & !out_ready, s/cout/out_valid are stable.
//   - Upstream stages fill; the pipeline holds at most NBLK results.
//   - in_ready=0 once all NBLK stages are valid and out_ready=0.
// - Simultaneous in/out transfer when full: both occur in the same cycle with no loss; in_ready stays 1.
// - in_valid=0 leaves stage 0 empty (valid=0). Data under valid=0 is don't-care.
// - Arithmetic is modulo 2^WIDTH and cout is the true carry: {cout,s} == x1+x2+cin exactly.
// - Reset mid-operation discards all in-flight results. out_valid=0 the cycle after rst sampled high.
// - NBLK=1 degenerates to a single registered adder stage.
// CONFIGURATION
// - `define CSKIP_SKIP_CNT_EN adds output skip_cnt [31:0]:
//   - each result carries popcount(gp vector) through the pipe;
//   - on each out_valid&out_ready transfer, skip_cnt += that popcount, saturating at 32'hFFFF_FFFF;
//   - rst clears skip_cnt to 0.
// - Without the macro: port absent, no counter logic; datapath and timing identical.
// TESTING
// - WIDTH=32,BLOCK=8, x1=32'hFFFF_FFFF x2=0 cin=1, out_ready=1 -> 4 cycles later s=0, cout=1 (all-skip path)
// - x1=32'h1234_5678 x2=32'h0FED_CBA9 cin=0 -> s=32'h2222_2221, cout=0 after exactly 4 cycles
// - 8 back-to-back inputs i*32'h1111_1111 + 1, out_ready=1 -> out_valid=1 for 8 consecutive cycles,
//   in order, s=i*32'h1111_1111+1
// - Send 6 inputs with out_ready=0:
//   - 4 accepted, then in_ready=0;
//   - raise out_ready -> all 6 delivered in order, none lost or duplicated.
// - rst=1 for one cycle with 3 results in flight -> out_valid=0 next cycle, s=0, cout=0; no stale result appears afterwards
// - CSKIP_SKIP_CNT_EN: deliver x1=32'h00FF_00FF x2=32'hFF00_FF00 -> skip_cnt=4; then x1=x2=0 -> skip_cnt stays 4
// - Random: 10k random x1/x2/cin with random out_ready throttling; {cout,s} checked against a golden model.
// - Random: also run WIDTH=16,BLOCK=4 and WIDTH=24,BLOCK=3.

Source files
------------

// File: rtl/cskip_pipe_adder.sv
// Pipelined carry-skip adder: {cout,s} = x1 + x2 + cin, one BLOCK-bit carry-skip block per stage.
// Latency: NBLK = WIDTH/BLOCK cycles from input transfer to out_valid; 1 result/cycle sustained.
// Backpressure: combinational ready chain; holds up to NBLK results, in_ready=0 only when full and out_ready=0.
//
// Ports:
//   clk, rst               sole clock; synchronous active-high reset
//   in_valid/in_ready      input handshake for x1, x2, cin
//   out_valid/out_ready    output handshake for s, cout
//   skip_cnt [31:0]        saturating count of skipped blocks over delivered results
//                          (present only when CSKIP_SKIP_CNT_EN is defined)
// Optional feature macro: CSKIP_SKIP_CNT_EN

module cskip_pipe_adder #(
   parameter int WIDTH = 32,
   parameter int BLOCK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x1,
   input  logic [WIDTH-1:0] x2,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout
`ifdef CSKIP_SKIP_CNT_EN
   ,
   output logic [31:0]      skip_cnt
`endif
);

   localparam int NBLK = WIDTH / BLOCK;
   localparam int CW   = $clog2(NBLK + 1);

   if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_bad_cfg
      $error("cskip_pipe_adder: WIDTH (%0d) must be a positive multiple of BLOCK (%0d)", WIDTH, BLOCK);
   end

   // One carry-skip block: returns {group_propagate, carry_out, sum}.
   // When every bit propagates the block carry-out is taken straight from the
   // block carry-in, bypassing the ripple chain.
   function automatic logic [BLOCK+1:0] blk_add(input logic [BLOCK-1:0] a,
                                                input logic [BLOCK-1:0] b,
                                                input logic             c);
      logic [BLOCK:0] t;
      logic           gp;
      t  = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, c};
      gp = &(a ^ b);
      return {gp, (gp ? c : t[BLOCK]), t[BLOCK-1:0]};
   endfunction

   // Stage registers. Sum bits above the finished blocks and operand bits at or
   // below the current block are don't-care and trim away in synthesis.
   logic [NBLK-1:0]  vld_q;
   logic [NBLK-1:0]  cry_q;
   logic [WIDTH-1:0] sum_q [NBLK];
   logic [WIDTH-1:0] a_q   [NBLK];
   logic [WIDTH-1:0] b_q   [NBLK];

   // Stage inputs (stage 0 from the ports, stage k from stage k-1) and next values.
   logic [NBLK-1:0]  in_v;
   logic [NBLK-1:0]  in_c;
   logic [WIDTH-1:0] in_s  [NBLK];
   logic [WIDTH-1:0] in_a  [NBLK];
   logic [WIDTH-1:0] in_b  [NBLK];
   logic [WIDTH-1:0] sum_d [NBLK];
   logic [NBLK-1:0]  cry_d;
   logic [NBLK-1:0]  ld;
   logic [BLOCK+1:0] r;

`ifdef CSKIP_SKIP_CNT_EN
   logic [CW-1:0]    cnt_q [NBLK];
   logic [CW-1:0]    in_n  [NBLK];
   logic [CW-1:0]    cnt_d [NBLK];
   logic [32:0]      skip_sum;
`endif

   // Ready chain: a stage may load when it is empty or its successor loads.
   always_comb begin
      logic nxt;
      nxt = out_ready;
      ld  = '0;
      for (int k = NBLK - 1; k >= 0; k--) begin
         ld[k] = !vld_q[k] || nxt;
         nxt   = ld[k];
      end
   end

   assign in_ready = ld[0];

   always_comb begin
      in_v[0] = in_valid;
      in_c[0] = cin;
      in_s[0] = '0;
      in_a[0] = x1;
      in_b[0] = x2;
`ifdef CSKIP_SKIP_CNT_EN
      in_n[0] = '0;
`endif
      for (int k = 1; k < NBLK; k++) begin
         in_v[k] = vld_q[k-1];
         in_c[k] = cry_q[k-1];
         in_s[k] = sum_q[k-1];
         in_a[k] = a_q[k-1];
         in_b[k] = b_q[k-1];
`ifdef CSKIP_SKIP_CNT_EN
         in_n[k] = cnt_q[k-1];
`endif
      end
   end

   always_comb begin
      r     = '0;
      cry_d = '0;
      for (int k = 0; k < NBLK; k++) begin
         r        = blk_add(in_a[k][k*BLOCK +: BLOCK], in_b[k][k*BLOCK +: BLOCK], in_c[k]);
         sum_d[k] = in_s[k];
         sum_d[k][k*BLOCK +: BLOCK] = r[BLOCK-1:0];
         cry_d[k] = r[BLOCK];
`ifdef CSKIP_SKIP_CNT_EN
         cnt_d[k] = in_n[k] + CW'(r[BLOCK+1]);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         cry_q <= '0;
         for (int k = 0; k < NBLK; k++) begin
            sum_q[k] <= '0;
            a_q[k]   <= '0;
            b_q[k]   <= '0;
`ifdef CSKIP_SKIP_CNT_EN
            cnt_q[k] <= '0;
`endif
         end
      end else begin
         for (int k = 0; k < NBLK; k++) begin
            if (ld[k]) begin
               vld_q[k] <= in_v[k];
               cry_q[k] <= cry_d[k];
               sum_q[k] <= sum_d[k];
               a_q[k]   <= in_a[k];
               b_q[k]   <= in_b[k];
`ifdef CSKIP_SKIP_CNT_EN
               cnt_q[k] <= cnt_d[k];
`endif
            end
         end
      end
   end

   assign out_valid = vld_q[NBLK-1];
   assign s         = sum_q[NBLK-1];
   assign cout      = cry_q[NBLK-1];

`ifdef CSKIP_SKIP_CNT_EN
   // Extra top bit detects wrap so the counter sticks at all-ones.
   assign skip_sum = {1'b0, skip_cnt} + 33'(cnt_q[NBLK-1]);

   always_ff @(posedge clk) begin
      if (rst) begin
         skip_cnt <= '0;
      end else if (out_valid && out_ready) begin
         skip_cnt <= skip_sum[32] ? 32'hFFFF_FFFF : skip_sum[31:0];
      end
   end
`endif

endmodule
